// File: rtl/srt4_quotient_fixup.sv
// SRT radix-4 quotient fix-up stage: on-the-fly conversion of signed digits into a
// binary quotient, final negative-remainder correction and remainder denormalization.
module srt4_quotient_fixup #(
    parameter int W  = 8,
    parameter int KW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          digit_valid,
    input  logic [2:0]    digit,
    input  logic          last,
    input  logic [W:0]    rem_in,
    input  logic [W-1:0]  divisor_n,
    input  logic [KW-1:0] k,
    output logic [W-1:0]  quotient,
    output logic [W-1:0]  remainder,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int CW = $clog2(W / 2 + 1);
    localparam logic [CW-1:0] HALF = CW'(W / 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_CORR,
        S_OUT
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  qm_q, qm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [W:0]    p_q, p_d;
    logic [W-1:0]  div_q, div_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  quot_q, quot_d;
    logic [W-1:0]  rem_q, rem_d;

    logic          illegal;
    logic          full;
    logic          pos;
    logic [W:0]    r_sum;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        qm_d    = qm_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        p_d     = p_q;
        div_d   = div_q;
        k_d     = k_q;
        quot_d  = quot_q;
        rem_d   = rem_q;

        illegal = (digit == 3'b011) || (digit == 3'b100) || (digit == 3'b101);
        full    = (cnt_q == HALF);
        pos     = !digit[2] && (digit[1:0] != 2'b00);
        r_sum   = p_q + (p_q[W] ? {1'b0, div_q} : {(W + 1){1'b0}});

        if (start) begin
            state_d = S_ACC;
            q_d     = '0;
            qm_d    = '1;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_ACC: begin
                    if (digit_valid) begin
                        if (illegal || full) begin
                            err_d = 1'b1;
                        end else begin
                            // Low digit bits double as 4+d for negative d; QM takes d-1 mod 4.
                            q_d   = {(digit[2] ? qm_q[W-3:0] : q_q[W-3:0]), digit[1:0]};
                            qm_d  = {(pos ? q_q[W-3:0] : qm_q[W-3:0]), digit[1:0] - 2'd1};
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (last) begin
                            state_d = S_CORR;
                            p_d     = rem_in;
                            div_d   = divisor_n;
                            k_d     = k;
                        end
                    end
                end
                S_CORR: begin
                    quot_d  = p_q[W] ? qm_q : q_q;
                    // A shift amount of W or more already yields zero.
                    rem_d   = r_sum[W-1:0] >> k_q;
                    state_d = S_OUT;
                end
                S_OUT: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            qm_q    <= '1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            p_q     <= '0;
            div_q   <= '0;
            k_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            qm_q    <= qm_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            p_q     <= p_d;
            div_q   <= div_d;
            k_q     <= k_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign busy      = (state_q == S_ACC) || (state_q == S_CORR);
    assign done      = (state_q == S_OUT);
    assign err       = err_q;

endmodule

// File: tb/tb_srt4_quotient_fixup.sv
// Directed bench for srt4_quotient_fixup: an integer-valued quotient model checked
// every cycle, plus literal expectations for each division.
module tb_srt4_quotient_fixup;

    localparam int W  = 8;
    localparam int KW = 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic          digit_valid;
    logic [2:0]    digit;
    logic          last;
    logic [W:0]    rem_in;
    logic [W-1:0]  divisor_n;
    logic [KW-1:0] k;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          busy;
    logic          done;
    logic          err;

    int total = 0;
    int bad   = 0;

    srt4_quotient_fixup #(.W(W), .KW(KW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .digit_valid (digit_valid),
        .digit       (digit),
        .last        (last),
        .rem_in      (rem_in),
        .divisor_n   (divisor_n),
        .k           (k),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Model: quotient as a plain integer sum of digits times powers of four.
    logic         m_acc = 1'b0;
    logic         m_corr = 1'b0;
    logic         m_err = 1'b0;
    logic         exp_done = 1'b0;
    logic [7:0]   exp_q = '0;
    logic [7:0]   exp_r = '0;
    longint       m_val = 0;
    int           m_cnt = 0;
    int           m_dv;
    int           m_tmp;
    logic [8:0]   m_p;
    logic [7:0]   m_b;
    logic [2:0]   m_k;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_acc = 0; m_corr = 0; m_err = 0; exp_done = 0;
            m_val = 0; m_cnt = 0; exp_q = '0; exp_r = '0;
        end else begin
            exp_done = 0;
            if (start) begin
                m_acc = 1; m_corr = 0; m_val = 0; m_cnt = 0; m_err = 0;
            end else if (m_corr) begin
                m_corr   = 0;
                exp_done = 1;
                exp_q    = 8'(m_p[8] ? m_val - 1 : m_val);
                m_tmp    = int'(m_p);
                if (m_p[8]) m_tmp = m_tmp - 512 + int'(m_b);
                exp_r    = 8'(m_tmp) >> m_k;
            end else if (m_acc && digit_valid) begin
                m_dv = int'(digit);
                if (digit[2]) m_dv = m_dv - 8;
                if (m_dv < -2 || m_dv > 2 || m_cnt == W / 2) begin
                    m_err = 1;
                end else begin
                    m_val = m_val * 4 + m_dv;
                    m_cnt++;
                end
                if (last) begin
                    m_acc = 0; m_corr = 1;
                    m_p = rem_in; m_b = divisor_n; m_k = k;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 32'(busy), 32'(m_acc || m_corr));
            chk("done", 32'(done), 32'(exp_done));
            chk("err", 32'(err), 32'(m_err));
            chk("quotient", 32'(quotient), 32'(exp_q));
            chk("remainder", 32'(remainder), 32'(exp_r));
        end
    end

    task automatic set_ops(input logic [8:0] r, input logic [7:0] b, input logic [2:0] kk);
        rem_in = r; divisor_n = b; k = kk;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic dig(input logic [2:0] d, input logic l);
        digit_valid = 1'b1; digit = d; last = l;
        @(negedge clk);
        digit_valid = 1'b0; last = 1'b0;
    endtask

    task automatic finish_check(input string nm, input logic [7:0] q, input logic [7:0] r,
                                input logic e);
        @(negedge clk);
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_q"}, 32'(quotient), 32'(q));
        chk({nm, "_r"}, 32'(remainder), 32'(r));
        chk({nm, "_err"}, 32'(err), 32'(e));
        chk({nm, "_model_q"}, 32'(exp_q), 32'(q));
        chk({nm, "_model_r"}, 32'(exp_r), 32'(r));
        $display("div %s: quotient=%02h remainder=%02h err=%0b", nm, quotient, remainder, err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; digit_valid = 1'b0; digit = '0; last = 1'b0;
        rem_in = '0; divisor_n = '0; k = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 64 - 32 + 8 - 1 = 39; 0x40 >> 3 = 8
        set_ops(9'h040, 8'h80, 3'd3);
        pulse_start();
        dig(3'b001, 0); dig(3'b110, 0); dig(3'b010, 0); dig(3'b111, 1);
        finish_check("mixed", 8'h27, 8'h08, 1'b0);

        // Q = 4, negative remainder: 4-1 = 3; (-3 + 128) >> 2 = 31
        set_ops(9'h1FD, 8'h80, 3'd2);
        pulse_start();
        dig(3'b000, 0); dig(3'b000, 0); dig(3'b001, 0); dig(3'b000, 1);
        finish_check("negrem", 8'h03, 8'd31, 1'b0);

        // -2 * 85 = -170, which is 0x56 mod 256
        set_ops(9'h000, 8'h80, 3'd0);
        pulse_start();
        repeat (3) dig(3'b110, 0);
        dig(3'b110, 1);
        finish_check("allneg", 8'h56, 8'h00, 1'b0);

        set_ops(9'h040, 8'h80, 3'd0);
        pulse_start();
        dig(3'b001, 0); dig(3'b100, 0);
        chk("illegal_err_next", 32'(err), 32'd1);
        dig(3'b001, 0); dig(3'b001, 0); dig(3'b001, 1);
        finish_check("illegal", 8'h55, 8'h40, 1'b1);
        repeat (2) @(negedge clk);
        chk("illegal_err_sticky", 32'(err), 32'd1);

        pulse_start();
        dig(3'b010, 0); dig(3'b010, 0);
        pulse_start();
        repeat (4) dig(3'b001, 0);
        chk("ovf_err_before", 32'(err), 32'd0);
        dig(3'b001, 1);
        chk("ovf_err_at5", 32'(err), 32'd1);
        finish_check("overflow", 8'h55, 8'h40, 1'b1);

        // Short division ended by an illegal last digit: Q = 2; 5 >> 1 = 2
        set_ops(9'h005, 8'h80, 3'd1);
        pulse_start();
        dig(3'b010, 0); dig(3'b011, 1);
        finish_check("short_illegal_last", 8'h02, 8'h02, 1'b1);

        // Digit coinciding with start is discarded: Q = 2, not 6; 0xFF >> 4 = 0x0F
        set_ops(9'h0FF, 8'h80, 3'd4);
        pulse_start();
        dig(3'b001, 0);
        start = 1'b1; digit_valid = 1'b1; digit = 3'b001;
        @(negedge clk);
        start = 1'b0; digit_valid = 1'b0;
        dig(3'b010, 1);
        finish_check("start_wins", 8'h02, 8'h0F, 1'b0);

        set_ops(9'h000, 8'h80, 3'd0);
        pulse_start();
        dig(3'b001, 0); dig(3'b001, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_q", 32'(quotient), 32'd0);
        chk("arst_r", 32'(remainder), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        repeat (3) dig(3'b001, 1);
        repeat (3) @(negedge clk);
        chk("arst_ignored_q", 32'(quotient), 32'd0);
        chk("arst_ignored_busy", 32'(busy), 32'd0);

        // 128 + 32 - 4 - 2 = 154, minus one = 0x99; (-16 + 192) >> 4 = 0x0B
        set_ops(9'h1F0, 8'hC0, 3'd4);
        pulse_start();
        dig(3'b010, 0); dig(3'b010, 0); dig(3'b111, 0); dig(3'b110, 1);
        finish_check("recover", 8'h99, 8'h0B, 1'b0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
